uart_rx_byte_fifo: RTL

- Downstream receive buffer for the UART receive FSM: captures each completed byte from the receiver on a one-cycle strobe and stores it in a synchronous FIFO.
- Presents bytes to the host/bus side through a read-request/registered-data handshake.
- Decouples byte arrival from the consumer and reports occupancy and overflow.

---
 rtl/uart_rx_byte_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo
// Receive-side byte buffer sitting behind the UART receive FSM. Each completed
// byte arrives on a one-cycle rx_valid strobe and is queued in a synchronous
// FIFO. The consumer pulls bytes with rd_en. The byte appears on rd_data one
// cycle later, flagged by a single-cycle rd_valid pulse.
//
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate counter. empty, full and level depend only on the
// pointer registers. There is no combinational path from any input to them.
//
// Build option:
//   UART_RX_FIFO_OVERWRITE_EN
//     Undefined (default): when the FIFO is full, a byte that arrives without
//       a read in the same cycle is dropped, and overflow is set.
//     Defined: in the same situation the oldest entry is discarded and the new
//       byte is stored, so the FIFO keeps the most recent DEPTH bytes. overflow
//       is still set.

module uart_rx_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            rd_acc;
    logic            wr_acc;
    logic            drop;
    logic            ovw;
    logic            store;

    // Status flags come straight from the registered pointers.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level = wr_ptr - rd_ptr;

    // A read frees a slot on the same edge, so a full FIFO can still take a
    // byte when it is also being read.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = rx_valid && (!full || rd_acc);
    assign drop   = rx_valid && full && !rd_acc;

`ifdef UART_RX_FIFO_OVERWRITE_EN
    // A byte that would be dropped instead replaces the oldest entry.
    assign ovw = drop;
`else
    assign ovw = 1'b0;
`endif

    assign store = !reset && (wr_acc || ovw);

    // Byte storage. Contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
        end
    end

    // Advance the write and read pointers. An overwrite moves both of them.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc || ovw) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc || ovw) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Registered read port. rd_data holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    // Sticky overflow flag. A new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
